// File: rtl/freq_bcd_encoder.sv
// freq_bcd_encoder: 20-bit binary frequency to six BCD digits with leading-zero blanking.
// Sequential double-dabble conversion: 20 shift cycles, one DONE cycle, one output cycle.
// Optional macro FREQ_BCD_SAT_EN: saturate inputs above 999_999 and raise ovf.
// Without the macro the millions digit is dropped (result is freq_in mod 1_000_000).
module freq_bcd_encoder #(
    parameter int BIN_W   = 20,
    parameter int DIG_NUM = 6
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   in_valid,
    input  logic [BIN_W-1:0]       freq_in,
    output logic                   busy,
    output logic                   out_valid,
    output logic [4*DIG_NUM-1:0]   bcd_out,
    output logic [DIG_NUM-1:0]     seg_en,
    output logic                   ovf
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [BIN_W-1:0]     r_sreg;
    logic [4*DIG_NUM-1:0] r_acc;
    logic [4:0]           r_cnt;
    logic                 r_pend;
    logic                 r_out_valid;
    logic [4*DIG_NUM-1:0] r_bcd;
    logic [DIG_NUM-1:0]   r_seg;
    logic [4*DIG_NUM-1:0] w_adj;
    logic [DIG_NUM-1:0]   w_seg;
    logic                 w_any;
    logic [BIN_W-1:0]     w_load;

`ifdef FREQ_BCD_SAT_EN
    logic w_ovf_in;
    logic r_ovf_pend;
    logic r_ovf;

    // Clamp out-of-range measurements to the largest displayable value.
    always_comb begin
        w_ovf_in = (freq_in > BIN_W'(999_999));
        w_load   = w_ovf_in ? BIN_W'(999_999) : freq_in;
    end

    // Overflow flag travels with the conversion and is published alongside the digits.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (r_state == StIdle && in_valid) begin
                r_ovf_pend <= w_ovf_in;
            end
            if (r_pend) begin
                r_ovf <= r_ovf_pend;
            end
        end
    end

    assign ovf = r_ovf;
`else
    // Millions digit falls off the top of the accumulator during shifting.
    always_comb begin
        w_load = freq_in;
    end

    assign ovf = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept only from IDLE, fixed BIN_W shift cycles.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid) w_state_next = StShift;
            StShift: if (r_cnt == 5'(BIN_W - 1)) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Add 3 to every nibble >= 5 ahead of the shift.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < DIG_NUM; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: a digit lights if it or any higher digit is nonzero.
    always_comb begin
        w_any = 1'b0;
        w_seg = '0;
        for (int i = DIG_NUM - 1; i >= 0; i--) begin
            w_any    = w_any | (|r_acc[4*i +: 4]);
            w_seg[i] = w_any;
        end
        w_seg[0] = 1'b1;
    end

    // Conversion datapath: load, shift, then one extra stage to publish the result.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sreg      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_out_valid <= 1'b0;
            r_bcd       <= '0;
            r_seg       <= DIG_NUM'(1);
        end else begin
            r_pend      <= (r_state == StDone);
            r_out_valid <= r_pend;
            if (r_pend) begin
                r_bcd <= r_acc;
                r_seg <= w_seg;
            end
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_sreg <= w_load;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                StShift: begin
                    r_acc  <= {w_adj[4*DIG_NUM-2:0], r_sreg[BIN_W-1]};
                    r_sreg <= {r_sreg[BIN_W-2:0], 1'b0};
                    r_cnt  <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != StIdle);
    assign out_valid = r_out_valid;
    assign bcd_out   = r_bcd;
    assign seg_en    = r_seg;

endmodule

// File: doc/freq_bcd_encoder.md
FREQ_BCD_ENCODER -- requirements
Module: freq_bcd_encoder

Interface
REQ-001 Parameter: BIN_W, 20, width of binary frequency input; fixed at 20 for this block.
REQ-002 Parameter: DIG_NUM, 6, number of BCD digits produced; fixed at 6.
REQ-003 sys_clk  input  1  single system clock; all logic on rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  one-cycle strobe; freq_in holds a new measurement result.
REQ-006 freq_in  input  20  binary frequency in Hz, from freq_meter_calc.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 out_valid  output  1  one-cycle strobe; bcd_out/seg_en updated this cycle.
REQ-009 bcd_out  output  24  six BCD digits; [3:0] units, [23:20] hundred-thousands; feeds seg_dynamic data input.
REQ-010 seg_en  output  6  per-digit enable with leading-zero blanking; bit i = digit i.
REQ-011 ovf  output  1  input exceeded 999_999 (see Configuration).

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE: on in_valid=1 SHALL latch freq_in into a 20-bit shift register, clear a 24-bit BCD accumulator, clear a 5-bit bit counter, go to SHIFT.
REQ-014 SHIFT: each cycle SHALL add 3 to every accumulator nibble >=5, then shift {accumulator, shift register} left one bit (double dabble), increment bit counter.
REQ-015 SHIFT SHALL last exactly BIN_W (20) cycles; after the shift with counter=19 SHALL go to DONE.
REQ-016 DONE: SHALL register accumulator into bcd_out, compute seg_en, pulse out_valid for one cycle, return to IDLE.
REQ-017 Latency: out_valid SHALL be high in the cycle beginning exactly 22 rising edges after the edge that sampled in_valid.
REQ-018 busy SHALL be high in SHIFT and DONE, low in IDLE.
REQ-019 in_valid while busy=1 SHALL be ignored; no queueing; current conversion unaffected.
REQ-020 in_valid in the same cycle as DONE SHALL be ignored; accepted only from IDLE.
REQ-021 bcd_out, seg_en, ovf SHALL hold their last values between out_valid pulses.
REQ-022 seg_en: bit 0 SHALL always be 1; bit i (i>=1) SHALL be 1 iff any digit j>=i is nonzero.
REQ-023 Every output nibble SHALL be a legal BCD digit (0-9).

Reset
REQ-024 sys_rst=1 SHALL asynchronously force FSM to IDLE, busy=0, out_valid=0, bcd_out=24'h000000, seg_en=6'b000001, ovf=0, internal registers to 0.
REQ-025 Reset during SHIFT or DONE SHALL abort the conversion; no out_valid after release until a new in_valid is accepted.
REQ-026 After release, first accepted in_valid SHALL produce a correct result with normal latency.

Configuration
REQ-027 Macro FREQ_BCD_SAT_EN controls overflow saturation.
REQ-028 Defined: freq_in > 999_999 latched in IDLE SHALL be replaced by 999_999 before conversion; ovf SHALL be set in DONE to 1, else 0.
REQ-029 Not defined: no comparison; the 7th (millions) digit SHALL be discarded, bcd_out = freq_in mod 1_000_000; ovf SHALL be tied 0.
REQ-030 Latency and handshake SHALL be identical in both builds.

Verification
REQ-031 freq_in=0, in_valid pulse -> 22 edges later out_valid=1, bcd_out=24'h000000, seg_en=6'b000001, ovf=0.
REQ-032 freq_in=123_456 -> bcd_out=24'h123456, seg_en=6'b111111; freq_in=5_000 -> bcd_out=24'h005000, seg_en=6'b001111.
REQ-033 freq_in=1_048_575: with FREQ_BCD_SAT_EN -> bcd_out=24'h999999, ovf=1; without -> bcd_out=24'h048575, ovf=0.
REQ-034 in_valid with 999_999, second in_valid with 1 asserted 5 cycles later -> single out_valid, bcd_out=24'h999999; busy high for 21 cycles.
REQ-035 sys_rst pulsed 10 cycles into a conversion of 654_321 -> outputs at reset values immediately, no out_valid; next in_valid 42 -> bcd_out=24'h000042, seg_en=6'b000011.
REQ-036 Random sweep 0..999_999, back-to-back accepted inputs -> every bcd_out equals decimal of freq_in, each out_valid exactly one cycle.
